cga_vram_sequencer: RTL and testbench

Time-division controller for the single CGA video RAM port. It shares the RAM between display fetch and CPU bus accesses on a fixed 8-cycle character slot. Each slot delivers one character byte and one attribute byte, or two graphics bytes, to the attribute/pixel stage. The block sits between the CRTC address generator, the ISA bus interface and the VRAM, and feeds `char_byte`/`att_byte` downstream.

---
 rtl/cga_vram_sequencer_pkg.sv | 32 +++
 rtl/cga_vram_sequencer_slot_timer.sv | 34 +++
 rtl/cga_vram_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cga_vram_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_vram_sequencer_pkg.sv
// Shared definitions for the CGA VRAM sequencer: slot phase constants,
// slot length, default VRAM address width, the CPU handshake state type
// and the display-fetch address mapping.
package cga_vram_sequencer_pkg;

   localparam int unsigned SLOT_LEN    = 8;
   localparam int unsigned VRAM_ADDR_W = 14;

   localparam logic [2:0] PH_FETCH_A = 3'd0;
   localparam logic [2:0] PH_FETCH_B = 3'd2;
   localparam logic [2:0] PH_CPU0    = 3'd4;
   localparam logic [2:0] PH_CPU1    = 3'd6;
   localparam logic [2:0] PH_LAST    = 3'(SLOT_LEN - 1);

   typedef enum logic [1:0] {
      CPU_IDLE,
      CPU_ACCESS,
      CPU_CAPTURE
   } cpu_state_e;

   // Byte address of the first (even) fetch byte; the second byte is the
   // same address with bit 0 set, so no carry can occur.
   function automatic logic [13:0] fetch_base(input logic        grph,
                                              input logic [12:0] crtc,
                                              input logic        row0);
      logic [13:0] a;
      if (grph) a = {row0, crtc[11:0], 1'b0};
      else      a = {crtc, 1'b0};
      return a;
   endfunction

endpackage

// File: rtl/cga_vram_sequencer_slot_timer.sv
// Character slot timer: free-running 3-bit phase counter (0..7).
//   phase      : current phase
//   next_phase : phase of the following cycle
//   start_stb  : odd phase; registered RAM drive for the slot starting next
//                cycle (its even phase) is decided now
//   cap_stb    : odd phase; RAM read data of the current slot is valid now
module cga_slot_timer
   import cga_vram_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] phase,
   output logic [2:0] next_phase,
   output logic       start_stb,
   output logic       cap_stb
);

   logic [2:0] phase_q, phase_d;

   always_comb begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) phase_q <= '0;
      else       phase_q <= phase_d;
   end

   assign phase      = phase_q;
   assign next_phase = phase_d;
   assign start_stb  = phase_q[0];
   assign cap_stb    = phase_q[0];

endmodule

// File: rtl/cga_vram_sequencer.sv
// CGA VRAM time-division sequencer. Each 8-cycle character slot gives
// phases 0-3 to display fetch (when fetch_en was latched in phase 7) and
// the remaining even/odd pairs to CPU accesses.
//   fetch_en/grph_mode/crtc_addr/row_addr0 : fetch control, sampled phase 7
//   cpu_*                                  : level request / ack handshake
//   ram_*                                  : single VRAM port, sync read
//   char_byte/att_byte/load_stb            : fetched bytes to pixel stage
module cga_vram_sequencer
   import cga_vram_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              grph_mode,
   input  logic [12:0]       crtc_addr,
   input  logic              row_addr0,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_dout,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        char_byte,
   output logic [7:0]        att_byte,
   output logic              load_stb
);

   logic [2:0] phase, next_phase;
   logic       start_stb, cap_stb;

   cga_slot_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .phase      (phase),
      .next_phase (next_phase),
      .start_stb  (start_stb),
      .cap_stb    (cap_stb)
   );

   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic [7:0]        char_byte_q, char_byte_d;
   logic [7:0]        att_byte_q, att_byte_d;
   logic              load_stb_q, load_stb_d;
   logic              fetch_lat_q, fetch_lat_d;
   logic [12:0]       base_q, base_d;
   logic [7:0]        a_hold_q, a_hold_d;
   logic [7:0]        b_hold_q, b_hold_d;
   logic              guard_q, guard_d;
   logic              cpu_wr_q, cpu_wr_d;
   cpu_state_e        cpu_st_q, cpu_st_d;

   logic              fetch_next, cpu_next;
   logic [13:0]       new_base;

   always_comb begin
      // Slot 0/1 belongs to the next character, so it follows the live
      // fetch_en being latched this cycle rather than the held copy.
      fetch_next = (next_phase == PH_FETCH_A) ? fetch_en : fetch_lat_q;
      cpu_next   = (next_phase == PH_CPU0) || (next_phase == PH_CPU1) || !fetch_next;
      new_base   = fetch_base(grph_mode, crtc_addr, row_addr0);

      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      cpu_dout_d  = cpu_dout_q;
      char_byte_d = char_byte_q;
      att_byte_d  = att_byte_q;
      load_stb_d  = 1'b0;
      fetch_lat_d = fetch_lat_q;
      base_d      = base_q;
      a_hold_d    = a_hold_q;
      b_hold_d    = b_hold_q;
      guard_d     = guard_q;
      cpu_wr_d    = cpu_wr_q;
      cpu_st_d    = cpu_st_q;

      if (start_stb && (next_phase == PH_FETCH_A)) begin
         fetch_lat_d = fetch_en;
         base_d      = new_base[13:1];
      end

      // Fetched bytes are staged and presented together at the next phase 0.
      if (cap_stb && fetch_lat_q) begin
         if (phase == PH_FETCH_A + 3'd1) a_hold_d = ram_rdata;
         if (phase == PH_FETCH_B + 3'd1) b_hold_d = ram_rdata;
         if (phase == PH_LAST) begin
            char_byte_d = a_hold_q;
            att_byte_d  = b_hold_q;
            load_stb_d  = 1'b1;
         end
      end

      case (cpu_st_q)
         CPU_ACCESS:  cpu_st_d = CPU_CAPTURE;
         CPU_CAPTURE: begin
            cpu_ack_d = 1'b1;
            if (!cpu_wr_q) cpu_dout_d = ram_rdata;
            cpu_st_d = CPU_IDLE;
         end
         default: ;
      endcase

      // The guard is armed on acceptance and consumed by the very next CPU
      // slot start, which lands on the edge the ack is issued.
      if (start_stb) begin
         if (!cpu_next) begin
            ram_addr_d = ADDR_W'((next_phase == PH_FETCH_A) ? new_base : {base_q, 1'b1});
         end else if (guard_q) begin
            guard_d = 1'b0;
         end else if (cpu_req) begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_din;
            cpu_wr_d    = cpu_we;
            guard_d     = 1'b1;
            cpu_st_d    = CPU_ACCESS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_dout_q  <= '0;
         char_byte_q <= '0;
         att_byte_q  <= '0;
         load_stb_q  <= 1'b0;
         fetch_lat_q <= 1'b0;
         base_q      <= '0;
         a_hold_q    <= '0;
         b_hold_q    <= '0;
         guard_q     <= 1'b0;
         cpu_wr_q    <= 1'b0;
         cpu_st_q    <= CPU_IDLE;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_dout_q  <= cpu_dout_d;
         char_byte_q <= char_byte_d;
         att_byte_q  <= att_byte_d;
         load_stb_q  <= load_stb_d;
         fetch_lat_q <= fetch_lat_d;
         base_q      <= base_d;
         a_hold_q    <= a_hold_d;
         b_hold_q    <= b_hold_d;
         guard_q     <= guard_d;
         cpu_wr_q    <= cpu_wr_d;
         cpu_st_q    <= cpu_st_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_dout  = cpu_dout_q;
   assign char_byte = char_byte_q;
   assign att_byte  = att_byte_q;
   assign load_stb  = load_stb_q;

endmodule

// File: tb/tb_cga_vram_sequencer.sv
// Randomized bench for cga_vram_sequencer against a cycle-count based
// reference model of the slot schedule, with a synchronous-read VRAM model.
module tb_cga_vram_sequencer;

   localparam int unsigned AW = 14;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fetch_en = 1'b0;
   logic          grph_mode = 1'b0;
   logic [12:0]   crtc_addr = '0;
   logic          row_addr0 = 1'b0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_dout;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata = '0;
   logic [7:0]    char_byte;
   logic [7:0]    att_byte;
   logic          load_stb;

   cga_vram_sequencer #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .fetch_en  (fetch_en),
      .grph_mode (grph_mode),
      .crtc_addr (crtc_addr),
      .row_addr0 (row_addr0),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_ack   (cpu_ack),
      .cpu_dout  (cpu_dout),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .char_byte (char_byte),
      .att_byte  (att_byte),
      .load_stb  (load_stb)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // VRAM contents (environment) and the model's own view of them.
   logic [7:0] mem     [16384];
   logic [7:0] ref_mem [16384];
   logic [7:0] rd_stage = '0;

   // Reference model state.
   int         cyc = 0;
   bit         fe_cur = 0;
   int         a_lat = 0;
   logic [7:0] pend_char = '0, pend_att = '0;
   bit         guard = 0;
   int         ack_due = -1;
   bit         ack_wr = 0;
   logic [7:0] ack_val = '0;
   logic [13:0] e_addr = '0;
   logic       e_we = 0, e_ack = 0, e_load = 0;
   logic [7:0] e_wdata = '0, e_dout = '0, e_char = '0, e_att = '0;

   // Requester state.
   int req_rate = 0;
   bit drop_pend = 0;
   bit force_wr = 0;

   // Expected outputs for the cycle that has just begun, from the inputs of
   // the cycle that just ended. Phase is simply cycles-since-reset mod 8.
   task automatic model_step();
      int p;
      if (reset) begin
         cyc = 0; fe_cur = 0; guard = 0; ack_due = -1;
         e_addr = '0; e_we = 0; e_wdata = '0; e_ack = 0; e_dout = '0;
         e_char = '0; e_att = '0; e_load = 0;
         return;
      end
      cyc++;
      p = cyc % 8;
      e_we = 0; e_ack = 0; e_load = 0;
      if (p == 0) begin
         if (fe_cur) begin
            e_char = pend_char; e_att = pend_att; e_load = 1;
         end
         fe_cur = fetch_en;
         if (grph_mode) a_lat = int'(row_addr0) * 8192 + (int'(crtc_addr) % 4096) * 2;
         else           a_lat = int'(crtc_addr) * 2;
      end
      if (fe_cur && p == 0) begin
         e_addr = 14'(a_lat);
         pend_char = ref_mem[a_lat];
      end else if (fe_cur && p == 2) begin
         e_addr = 14'(a_lat + 1);
         pend_att = ref_mem[a_lat + 1];
      end else if (p % 2 == 0) begin
         if (guard) guard = 0;
         else if (cpu_req) begin
            e_addr = cpu_addr; e_we = cpu_we; e_wdata = cpu_din;
            guard = 1; ack_due = cyc + 2; ack_wr = cpu_we;
            ack_val = ref_mem[int'(cpu_addr)];
            if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_din;
         end
      end
      if (cyc == ack_due) begin
         e_ack = 1;
         if (!ack_wr) e_dout = ack_val;
      end
   endtask

   task automatic check_outputs();
      chk("ram_we",    32'(ram_we),    32'(e_we));
      chk("ram_addr",  32'(ram_addr),  32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      chk("cpu_ack",   32'(cpu_ack),   32'(e_ack));
      chk("cpu_dout",  32'(cpu_dout),  32'(e_dout));
      chk("char_byte", 32'(char_byte), 32'(e_char));
      chk("att_byte",  32'(att_byte),  32'(e_att));
      chk("load_stb",  32'(load_stb),  32'(e_load));
   endtask

   task automatic requester();
      if (reset) begin
         cpu_req = 0; drop_pend = 0;
         return;
      end
      if (cpu_ack === 1'b1) begin
         if ($urandom_range(1) == 0) cpu_req = 0;
         else drop_pend = 1;
      end else if (drop_pend) begin
         cpu_req = 0; drop_pend = 0;
      end else if (!cpu_req && $urandom_range(99) < req_rate) begin
         cpu_req  = 1;
         cpu_we   = force_wr ? 1'b1 : 1'($urandom_range(1));
         cpu_addr = ($urandom_range(1) == 1) ? 14'(32'h100 + $urandom_range(15)) : 14'($urandom);
         cpu_din  = 8'($urandom);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      ram_rdata = rd_stage;
      rd_stage  = mem[int'(ram_addr)];
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      requester();
   endtask

   task automatic preload(input int a, input logic [7:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   task automatic randomize_fetch();
      fetch_en  = 1'($urandom_range(3) != 0);
      grph_mode = 1'($urandom_range(1));
      row_addr0 = 1'($urandom_range(1));
      crtc_addr = 13'($urandom);
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 16384; i++) preload(i, 8'($urandom));

      reset = 1;
      repeat (3) cycle();
      reset = 0;

      // Text fetch.
      preload(32'h246, 8'h41);
      preload(32'h247, 8'h1F);
      fetch_en = 1; grph_mode = 0; crtc_addr = 13'h0123;
      repeat (24) cycle();
      chk("txt_char", 32'(char_byte), 32'h41);
      chk("txt_att",  32'(att_byte),  32'h1F);

      // Graphics fetch.
      grph_mode = 1; row_addr0 = 1; crtc_addr = 13'h0010;
      repeat (16) cycle();

      // CPU read raised in phase 1 while fetching.
      preload(32'h100, 8'hA5);
      for (int i = 0; i < 8 && (cyc % 8) != 0; i++) cycle();
      cycle();
      cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0100;
      seen = 0;
      for (int i = 0; i < 16 && !seen; i++) begin
         cycle();
         if (cpu_ack === 1'b1) begin
            seen = 1;
            chk("rd_ack_phase", 32'(cyc % 8), 32'd6);
            chk("rd_dout", 32'(cpu_dout), 32'hA5);
         end
      end
      chk("rd_ack_seen", 32'(seen), 32'd1);
      repeat (8) cycle();

      // Random mix.
      req_rate = 50;
      for (int i = 0; i < 1500; i++) begin
         cycle();
         randomize_fetch();
      end

      // Fetch disabled, back-to-back writes.
      fetch_en = 0; force_wr = 1; req_rate = 100;
      repeat (200) cycle();

      // Reset during a CPU write.
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         cycle();
         if (ram_we === 1'b1) seen = 1;
      end
      chk("wait_we", 32'(seen), 32'd1);
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_we",  32'(ram_we),  32'd0);
         chk("rst_ack", 32'(cpu_ack), 32'd0);
      end
      reset = 0;
      force_wr = 0;

      for (int i = 0; i < 600; i++) begin
         cycle();
         randomize_fetch();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
